// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on both sides.
// Single-cycle add/sub/logic/shift ops. The multiply is an iterative shift-add
// that takes WIDTH cycles. The result is held in DONE until the consumer takes it.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a new operation (in_ready=1)
// MUL    | shift-add multiply in progress (busy=1), one multiplier bit per cycle
// DONE   | result on out with out_valid=1, waiting for out_ready
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 2*WIDTH,
  parameter int SH_W  = $clog2(OUT_W)+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       con_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_mul_last;
  logic             w_sh_big;
  logic [SH_W-1:0]  w_sh_amt;
  logic [OUT_W-1:0] w_a_ext;
  logic [OUT_W-1:0] w_b_ext;
  logic [OUT_W-1:0] w_a_sext;
  logic [OUT_W-1:0] w_sra;
  logic [OUT_W-1:0] w_alu_res;
  logic [OUT_W-1:0] w_acc_nxt;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_mul_last = (r_cnt == CNT_W'(WIDTH-1));

  assign w_a_ext  = {{WIDTH{1'b0}}, in1};
  assign w_b_ext  = {{WIDTH{1'b0}}, in2};
  assign w_a_sext = {{WIDTH{in1[WIDTH-1]}}, in1};

  // The full in2 value is compared against OUT_W. Below that bound the
  // amount always fits in SH_W bits, so the shifters only need the low slice.
  assign w_sh_big = (in2 >= WIDTH'(OUT_W));
  assign w_sh_amt = in2[SH_W-1:0];
  assign w_sra    = $signed(w_a_sext) >>> w_sh_amt;

  // The multiplicand is added in when the current multiplier LSB is set.
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Single-cycle result for every non-multiply opcode
  always_comb begin
    w_alu_res = '0;
    case (con_sig)
      OP_ADD:  w_alu_res = w_a_ext + w_b_ext;
      OP_AND:  w_alu_res = w_a_ext & w_b_ext;
      OP_OR:   w_alu_res = w_a_ext | w_b_ext;
      OP_SLL:  w_alu_res = w_sh_big ? '0 : (w_a_ext << w_sh_amt);
      OP_SRL:  w_alu_res = w_sh_big ? '0 : (w_a_ext >> w_sh_amt);
      OP_SUB:  w_alu_res = w_a_ext - w_b_ext;
      OP_SRA:  w_alu_res = w_sh_big ? {OUT_W{in1[WIDTH-1]}} : w_sra;
      default: w_alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (con_sig == OP_MUL) ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (w_mul_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_MUL:   busy      = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: latch operands, step the shift-add engine, write the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (con_sig == OP_MUL) begin
              r_mcand  <= w_a_ext;
              r_mplier <= in2;
              r_acc    <= '0;
              r_cnt    <= '0;
            end else begin
              r_out <= w_alu_res;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_out <= w_acc_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=16. A timeline model tracks the pending operation,
// its expected value from plain arithmetic, and the number of cycles left
// before the result appears. Every cycle, all outputs are compared against it.
module tb_seq_alu;

  localparam int W  = 16;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic [2:0]    con_sig;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out;
  logic          busy;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .con_sig   (con_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int dut_hs  = 0;

  // model state
  bit            m_pend = 1'b0;
  bit            m_mul  = 1'b0;
  int            m_left = 0;
  logic [OW-1:0] m_exp  = '0;
  logic [OW-1:0] m_last = '0;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [63:0]        ea;
    logic [63:0]        eb;
    logic signed [31:0] s;
    ea = 64'(a);
    eb = 64'(b);
    s  = {{16{a[15]}}, a};
    case (op)
      3'd0:    return 32'(ea + eb);
      3'd1:    return 32'(ea * eb);
      3'd2:    return 32'(ea & eb);
      3'd3:    return 32'(ea | eb);
      3'd4:    return (b >= 16'd32) ? 32'd0 : 32'(ea << b);
      3'd5:    return (b >= 16'd32) ? 32'd0 : 32'(ea >> b);
      3'd6:    return 32'(ea - eb);
      default: return (b >= 16'd32) ? {32{a[15]}} : 32'(s >>> b);
    endcase
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // One clock: apply the edge to the model using the driven inputs, then
  // compare every output at the falling edge.
  task automatic step();
    if (out_valid && out_ready) dut_hs++;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_pend = 1'b0;
      m_left = 0;
      m_last = '0;
    end else if (m_pend) begin
      if (m_left == 0) begin
        if (out_ready) begin
          m_pend = 1'b0;
          m_last = m_exp;
        end
      end else begin
        m_left--;
      end
    end else if (in_valid) begin
      m_pend = 1'b1;
      m_mul  = (con_sig == 3'd1);
      m_left = m_mul ? W : 0;
      m_exp  = ref_alu(con_sig, in1, in2);
    end
    @(negedge clk);
    check("in_ready",  in_ready,  !m_pend);
    check("out_valid", out_valid, m_pend && m_left == 0);
    check("busy",      busy,      m_pend && m_mul && m_left > 0);
    check("out",       out,       (m_pend && m_left == 0) ? m_exp : m_last);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit took;
    int guard;
    took     = 1'b0;
    guard    = 0;
    in_valid = 1'b1;
    con_sig  = op;
    in1      = a;
    in2      = b;
    while (!took && guard < 200) begin
      took = !m_pend && !rst;
      step();
      guard++;
    end
    if (!took) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in1      = 16'($urandom);
    in2      = 16'($urandom);
    con_sig  = 3'($urandom);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (m_pend && g < 100) begin
      step();
      g++;
    end
    if (m_pend) check("idle_timeout", 0, 1);
  endtask

  task automatic mul_latency(input logic [W-1:0] a, input logic [W-1:0] b, input logic [31:0] exp);
    int n;
    int bc;
    issue(3'd1, a, b);
    n  = 1;
    bc = busy ? 1 : 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
      if (busy) bc++;
    end
    check("mul_latency", n, 17);
    check("mul_busy_cycles", bc, 16);
    check("mul_value", out, exp);
    wait_idle();
  endtask

  initial begin
    int hs0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    con_sig   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("reset_out", out, 32'h0);
    check("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // pin the reference model with hand-computed values
    check("ref_add",  ref_alu(3'd0, 16'hFFFF, 16'h0001), 32'h0001_0000);
    check("ref_mul",  ref_alu(3'd1, 16'hFFFF, 16'hFFFF), 32'hFFFE_0001);
    check("ref_sll",  ref_alu(3'd4, 16'h0001, 16'd31),   32'h8000_0000);
    check("ref_sra",  ref_alu(3'd7, 16'h8000, 16'd4),    32'hFFFF_F800);
    check("ref_sub",  ref_alu(3'd6, 16'd3, 16'd5),       32'hFFFF_FFFE);

    // add with carry, then the handshake reopens in_ready
    out_ready = 1'b1;
    issue(3'd0, 16'hFFFF, 16'h0001);
    check("add_valid", out_valid, 1'b1);
    check("add_value", out, 32'h0001_0000);
    step();
    check("add_ready_back", in_ready, 1'b1);

    mul_latency(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    mul_latency(16'h1234, 16'h0000, 32'h0000_0000);

    issue(3'd4, 16'h0001, 16'd31); check("sll31", out, 32'h8000_0000); wait_idle();
    issue(3'd4, 16'h0001, 16'd32); check("sll32", out, 32'h0);         wait_idle();
    issue(3'd5, 16'h8000, 16'd15); check("srl15", out, 32'h1);         wait_idle();
    issue(3'd7, 16'h8000, 16'd4);  check("sra4",  out, 32'hFFFF_F800); wait_idle();
    issue(3'd7, 16'h8000, 16'd40); check("sra40", out, 32'hFFFF_FFFF); wait_idle();

    // back-pressure with a competing request during the stall
    out_ready = 1'b0;
    hs0 = dut_hs;
    issue(3'd6, 16'd3, 16'd5);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      con_sig  = 3'd0;
      in1      = 16'($urandom);
      in2      = 16'($urandom);
      step();
      check("stall_out", out, 32'hFFFF_FFFE);
      check("stall_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    check("stall_one_result", dut_hs - hs0, 1);

    // reset on the eighth cycle of a multiply
    issue(3'd1, 16'h1234, 16'h5678);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mul_out", out, 32'h0);
    check("rst_mul_valid", out_valid, 1'b0);
    check("rst_mul_busy", busy, 1'b0);
    check("rst_mul_ready", in_ready, 1'b1);
    issue(3'd2, 16'hF0F0, 16'h0FF0);
    check("and_after_rst", out, 32'h0000_00F0);
    wait_idle();

    // back-to-back stream
    hs0 = dut_hs;
    issue(3'd0, 16'h1234, 16'h4321);
    issue(3'd3, 16'hA500, 16'h005A);
    issue(3'd1, 16'h00FF, 16'h0101);
    issue(3'd5, 16'hF000, 16'd4);
    wait_idle();
    step();
    check("stream_count", dut_hs - hs0, 4);

    // randomized traffic with random back-pressure and occasional reset
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      con_sig   = 3'($urandom);
      in1       = pick();
      in2       = (con_sig[2] && con_sig != 3'd6) ? 16'($urandom_range(0, 40)) : pick();
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
